// File: rtl/uart_tx_if.sv
// Signal bundle between the THR FIFO / format decoder and the UART transmit engine.
// Master drives format, FIFO status and flow control; slave (the engine) drives TxD and status.
interface uart_tx_if #(
    parameter int pDataW = 9
);
    logic              ce_ovs;
    logic [3:0]        len;
    logic [1:0]        stop;
    logic              par_en;
    logic [1:0]        par;
    logic              hs_en;
    logic              cts_i;
    logic              tf_ef;
    logic [pDataW-1:0] thr;
    logic              tf_re;
    logic              brk;
    logic              txd;
    logic              tx_idle;
    logic              tx_start;
    logic              tx_shift;
    logic              tx_stop;
    logic              tx_brk;

    modport master (
        output ce_ovs, len, stop, par_en, par, hs_en, cts_i, tf_ef, thr, brk,
        input  tf_re, txd, tx_idle, tx_start, tx_shift, tx_stop, tx_brk
    );

    modport slave (
        input  ce_ovs, len, stop, par_en, par, hs_en, cts_i, tf_ef, thr, brk,
        output tf_re, txd, tx_idle, tx_start, tx_shift, tx_stop, tx_brk
    );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: compact state machine plus bit counter serialising THR words onto TxD.
// Break generation is compiled in only when UART_TX_BREAK_EN is defined.
module uart_tx_engine #(
    parameter int pOvs   = 16,
    parameter int pDataW = 9
) (
    input  logic     i_clk,
    input  logic     i_rst,
    uart_tx_if.slave bus
);
    localparam int              OW       = $clog2(pOvs);
    localparam logic [OW-1:0]   OVS_LAST = OW'(pOvs - 1);
    localparam logic [OW-1:0]   OVS_HALF = OW'(pOvs / 2 - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START_DLY = 3'd1;
    localparam logic [2:0] S_START_BIT = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_PARITY    = 3'd4;
    localparam logic [2:0] S_STOP      = 3'd5;
    localparam logic [2:0] S_STOP_DLY  = 3'd6;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] S_BREAK     = 3'd7;
`endif

    logic [2:0]        r_state;
    logic [OW-1:0]     r_ovs;
    logic [3:0]        r_bit_cnt;
    logic [pDataW-1:0] r_tsr;
    logic [3:0]        r_len;
    logic              r_par_en;
    logic              r_par_bit;
    logic [1:0]        r_stop;
    logic              r_txd;

    logic [2:0]        w_next;
    logic [3:0]        w_bit_nxt;
    logic              w_load;
    logic              w_ce_bit;
    logic              w_half;
    logic              w_cts_ok;
    logic [3:0]        w_len;
    logic              w_par_x;
    logic              w_par_bit;
    logic              w_stop_end;
    logic              w_data_bit;
    logic              w_txd;

    assign w_ce_bit = bus.ce_ovs && (r_ovs == OVS_LAST);
    assign w_half   = bus.ce_ovs && (r_ovs == OVS_HALF);
    assign w_cts_ok = !bus.hs_en || bus.cts_i;

    // Format capture: clamp Len and compute the parity bit over only the Len LSBs.
    always_comb begin
        w_len = bus.len;
        if (bus.len < 4'd5)
            w_len = 4'd5;
        else if (bus.len > 4'(pDataW))
            w_len = 4'(pDataW);
        w_par_x = 1'b0;
        for (int i = 0; i < pDataW; i++)
            if (i < int'(w_len))
                w_par_x = w_par_x ^ bus.thr[i];
        case (bus.par)
            2'd0:    w_par_bit = ~w_par_x;
            2'd1:    w_par_bit = w_par_x;
            2'd2:    w_par_bit = 1'b0;
            default: w_par_bit = 1'b1;
        endcase
    end

    // 1.5 stop bits: the second stop bit ends at the half-bit point of the divider.
    always_comb begin
        case (r_stop)
            2'd0:    w_stop_end = w_ce_bit;
            2'd1:    w_stop_end = w_half && (r_bit_cnt == 4'd1);
            default: w_stop_end = w_ce_bit && (r_bit_cnt == 4'd1);
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_bit_nxt = r_bit_cnt;
        w_load    = 1'b0;
        case (r_state)
            S_IDLE: if (bus.ce_ovs) begin
`ifdef UART_TX_BREAK_EN
                if (bus.brk) begin
                    w_next    = S_BREAK;
                    w_bit_nxt = 4'd0;
                end else
`endif
                if (!bus.tf_ef)
                    w_next = S_START_DLY;
            end
            S_START_DLY, S_STOP_DLY: if (w_ce_bit) begin
                w_bit_nxt = 4'd0;
`ifdef UART_TX_BREAK_EN
                if (r_state == S_STOP_DLY && bus.brk)
                    w_next = S_BREAK;
                else
`endif
                if (bus.tf_ef)
                    w_next = S_IDLE;
                else if (w_cts_ok) begin
                    w_load = 1'b1;
                    w_next = S_START_BIT;
                end else
                    w_next = S_START_DLY;
            end
            S_START_BIT: if (w_ce_bit) begin
                w_next    = S_DATA;
                w_bit_nxt = 4'd0;
            end
            S_DATA: if (w_ce_bit) begin
                if (r_bit_cnt == r_len - 4'd1) begin
                    w_next    = r_par_en ? S_PARITY : S_STOP;
                    w_bit_nxt = 4'd0;
                end else
                    w_bit_nxt = r_bit_cnt + 4'd1;
            end
            S_PARITY: if (w_ce_bit) begin
                w_next    = S_STOP;
                w_bit_nxt = 4'd0;
            end
            S_STOP: if (w_stop_end) begin
                w_bit_nxt = 4'd0;
`ifdef UART_TX_BREAK_EN
                if (bus.brk)
                    w_next = S_BREAK;
                else
`endif
                if (bus.tf_ef)
                    w_next = S_STOP_DLY;
                else if (w_cts_ok) begin
                    w_load = 1'b1;
                    w_next = S_START_BIT;
                end else
                    w_next = S_START_DLY;
            end else if (w_ce_bit)
                w_bit_nxt = r_bit_cnt + 4'd1;
`ifdef UART_TX_BREAK_EN
            // Bit counter 0 = spacing until Brk falls at a bit boundary, 1..2 = trailing mark bits.
            S_BREAK: if (w_ce_bit) begin
                if (r_bit_cnt == 4'd0) begin
                    if (!bus.brk)
                        w_bit_nxt = 4'd1;
                end else if (r_bit_cnt == 4'd1)
                    w_bit_nxt = 4'd2;
                else begin
                    w_next    = S_IDLE;
                    w_bit_nxt = 4'd0;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_data_bit = 1'b0;
        for (int i = 0; i < pDataW; i++)
            if (r_bit_cnt == 4'(i))
                w_data_bit = r_tsr[i];
        case (r_state)
            S_START_BIT: w_txd = 1'b0;
            S_DATA:      w_txd = w_data_bit;
            S_PARITY:    w_txd = r_par_bit;
`ifdef UART_TX_BREAK_EN
            S_BREAK:     w_txd = (r_bit_cnt != 4'd0);
`endif
            default:     w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ovs     <= '0;
            r_bit_cnt <= 4'd0;
            r_tsr     <= '0;
            r_len     <= 4'd0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop    <= 2'd0;
            r_txd     <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_bit_cnt <= w_bit_nxt;
            r_txd     <= w_txd;
            if (w_next != r_state || w_next == S_IDLE)
                r_ovs <= '0;
            else if (bus.ce_ovs)
                r_ovs <= (r_ovs == OVS_LAST) ? '0 : r_ovs + 1'b1;
            if (w_load) begin
                r_tsr     <= bus.thr;
                r_len     <= w_len;
                r_par_en  <= bus.par_en;
                r_par_bit <= w_par_bit;
                r_stop    <= bus.stop;
            end
        end
    end

    assign bus.tf_re    = w_load && !i_rst;
    assign bus.txd      = r_txd;
    assign bus.tx_idle  = (r_state == S_IDLE);
    assign bus.tx_start = (r_state == S_START_DLY);
    assign bus.tx_shift = (r_state == S_START_BIT) || (r_state == S_DATA) ||
                          (r_state == S_PARITY)    || (r_state == S_STOP);
    assign bus.tx_stop  = (r_state == S_STOP);
`ifdef UART_TX_BREAK_EN
    assign bus.tx_brk   = (r_state == S_BREAK) && (r_bit_cnt == 4'd0);
`else
    assign bus.tx_brk   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus queues expected frames, a serial monitor
// decodes TxD mid-bit and compares against the queue.
module tb_uart_tx_engine;
    typedef struct packed {
        logic [8:0] data;
        logic [3:0] nbits;
        logic       has_par;
        logic       par;
    } exp_t;

    typedef struct packed {
        logic [3:0] len;
        logic       par_en;
        logic [1:0] par;
        logic [8:0] thr;
        exp_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   re_cnt = 0;
    int   re0;
    int   n;
    int   low_cnt;
    int   mark_cnt;
    logic re_seen  = 1'b0;
    logic mon_en   = 1'b0;
    logic mon_busy = 1'b0;
    logic prev_txd = 1'b1;
    logic [8:0] fifo[$];
    exp_t       exp_q[$];
    exp_t       m_e;
    logic [8:0] m_got;
    vec_t       vecs[6];

    uart_tx_if #(.pDataW(9)) bus();

    uart_tx_engine #(.pOvs(16), .pDataW(9)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic send(input logic [8:0] w, input exp_t e);
        fifo.push_back(w);
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 4000 && !(exp_q.size() == 0 && fifo.size() == 0 && bus.tx_idle && !mon_busy)) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, k < 4000, 1);
    endtask

    // FIFO model: a read strobe seen in a cycle pops the word just after the loading edge.
    always @(negedge clk) begin
        re_seen = bus.tf_re;
        if (bus.tf_re) begin
            re_cnt++;
            check("re_while_empty", bus.tf_ef, 0);
        end
    end

    always @(posedge clk) begin
        #1;
        if (re_seen && fifo.size() > 0)
            void'(fifo.pop_front());
        bus.tf_ef = (fifo.size() == 0);
        bus.thr   = (fifo.size() > 0) ? fifo[0] : 9'h000;
    end

    // Serial monitor: sample each bit at its centre (8 clocks after the start edge, then every 16).
    always @(negedge clk) begin
        if (mon_en && prev_txd && !bus.txd) begin
            mon_busy = 1'b1;
            repeat (8) @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected got frame expected none at %0t", $time);
            end else begin
                m_e = exp_q.pop_front();
                check("start_bit", bus.txd, 0);
                m_got = '0;
                for (int i = 0; i < int'(m_e.nbits); i++) begin
                    repeat (16) @(negedge clk);
                    m_got[i] = bus.txd;
                end
                check("data", m_got, m_e.data);
                if (m_e.has_par) begin
                    repeat (16) @(negedge clk);
                    check("parity", bus.txd, m_e.par);
                end
                repeat (16) @(negedge clk);
                check("stop_bit", bus.txd, 1);
            end
            mon_busy = 1'b0;
        end
        prev_txd = bus.txd;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ce_ovs = 1'b1;
        bus.len    = 4'd8;
        bus.stop   = 2'd0;
        bus.par_en = 1'b0;
        bus.par    = 2'd0;
        bus.hs_en  = 1'b0;
        bus.cts_i  = 1'b0;
        bus.brk    = 1'b0;

        vecs[0] = '{4'd8,  1'b0, 2'd0, 9'h055, '{9'h055, 4'd8, 1'b0, 1'b0}};
        vecs[1] = '{4'd7,  1'b1, 2'd0, 9'h003, '{9'h003, 4'd7, 1'b1, 1'b1}};
        vecs[2] = '{4'd7,  1'b1, 2'd1, 9'h003, '{9'h003, 4'd7, 1'b1, 1'b0}};
        vecs[3] = '{4'd7,  1'b1, 2'd3, 9'h003, '{9'h003, 4'd7, 1'b1, 1'b1}};
        vecs[4] = '{4'd3,  1'b1, 2'd1, 9'h1F6, '{9'h016, 4'd5, 1'b1, 1'b1}};
        vecs[5] = '{4'd15, 1'b1, 2'd1, 9'h1A5, '{9'h1A5, 4'd9, 1'b1, 1'b1}};

        repeat (3) @(negedge clk);
        check("reset_txd",   bus.txd,      1);
        check("reset_idle",  bus.tx_idle,  1);
        check("reset_tf_re", bus.tf_re,    0);
        check("reset_brk",   bus.tx_brk,   0);
        check("reset_shift", bus.tx_shift, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        foreach (vecs[v]) begin
            bus.len    = vecs[v].len;
            bus.par_en = vecs[v].par_en;
            bus.par    = vecs[v].par;
            re0 = re_cnt;
            send(vecs[v].thr, vecs[v].e);
            wait_idle("frame");
            check("frame_re_count", re_cnt - re0, 1);
        end

        // Back-to-back words with 1.5 stop bits.
        bus.len    = 4'd8;
        bus.par_en = 1'b0;
        bus.stop   = 2'd1;
        re0 = re_cnt;
        send(9'h0A5, '{9'h0A5, 4'd8, 1'b0, 1'b0});
        send(9'h05A, '{9'h05A, 4'd8, 1'b0, 1'b0});
        n = 0;
        do begin @(negedge clk); n++; end while (n < 400 && !bus.tx_stop);
        check("stop15_reached", bus.tx_stop, 1);
        n = 0;
        while (n < 100 && bus.tx_stop) begin @(negedge clk); n++; end
        check("stop15_length", n, 24);
        check("stop15_next_start", bus.tx_shift, 1);
        check("stop15_no_idle", bus.tx_idle, 0);
        wait_idle("stop15");
        check("stop15_re_count", re_cnt - re0, 2);
        bus.stop = 2'd0;

        // CTS flow control holds the word in StartDelay.
        bus.hs_en = 1'b1;
        bus.cts_i = 1'b0;
        re0 = re_cnt;
        send(9'h0C3, '{9'h0C3, 4'd8, 1'b0, 1'b0});
        repeat (100) @(negedge clk);
        check("cts_hold_start", bus.tx_start, 1);
        check("cts_hold_txd",   bus.txd,      1);
        check("cts_hold_re",    re_cnt - re0, 0);
        bus.cts_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (n < 40 && !bus.tx_shift);
        check("cts_latency", (n >= 1 && n <= 16), 1);
        wait_idle("cts");
        check("cts_re_count", re_cnt - re0, 1);
        bus.hs_en = 1'b0;
        bus.cts_i = 1'b0;

        // Reset in the middle of data bit 3 of an all-zero word.
        mon_en = 1'b0;
        fifo.push_back(9'h000);
        n = 0;
        do begin @(negedge clk); n++; end while (n < 200 && !bus.tf_re);
        check("rst_test_load", bus.tf_re, 1);
        repeat (72) @(negedge clk);
        check("pre_rst_txd",   bus.txd,      0);
        check("pre_rst_shift", bus.tx_shift, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_txd",   bus.txd,     1);
        check("rst_idle",  bus.tx_idle, 1);
        check("rst_tf_re", bus.tf_re,   0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

`ifdef UART_TX_BREAK_EN
        mon_en   = 1'b0;
        re0      = re_cnt;
        low_cnt  = 0;
        mark_cnt = 0;
        bus.brk  = 1'b1;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (!bus.txd) low_cnt++;
        end
        check("brk_active", bus.tx_brk, 1);
        bus.brk = 1'b0;
        for (int i = 0; i < 100 && !bus.tx_idle; i++) begin
            @(negedge clk);
            if (!bus.txd) low_cnt++;
            if (!bus.tx_brk && !bus.tx_idle) mark_cnt++;
        end
        check("brk_low_bits", low_cnt >= 640, 1);
        check("brk_mark_len", mark_cnt, 32);
        check("brk_idle",     bus.tx_idle, 1);
        check("brk_no_re",    re_cnt - re0, 0);
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
`endif

        wait_idle("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
